// File: rtl/mod_reduce.sv
// -----------------------------------------------------------------------------
// mod_reduce
//   Computes result = in_a mod in_n for WIDTH-bit unsigned operands with a
//   restoring shift-subtract loop. The loop consumes one dividend bit per clock,
//   MSB first. A request sampled in IDLE is processed for exactly WIDTH RUN
//   cycles. The remainder is then registered, and done pulses for the one DONE
//   cycle. A modulus of zero returns the dividend unchanged.
//
// Ports
//   clk     in   1      clock, rising edge
//   resetn  in   1      synchronous reset, asserted HIGH (legacy name)
//   start   in   1      request, sampled only in IDLE
//   in_a    in   WIDTH  dividend, unsigned
//   in_n    in   WIDTH  modulus, unsigned
//   result  out  WIDTH  registered remainder, held until next completion/reset
//   done    out  1      one-cycle completion pulse
// -----------------------------------------------------------------------------
module mod_reduce #(
    parameter int WIDTH = 512
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_n,
    output logic [WIDTH-1:0] result,
    output logic             done
);

    // Sized so the counter can represent WIDTH-1 for any WIDTH >= 1.
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_done;

    logic [WIDTH-1:0]   r_a;        // captured dividend, shifted left each iteration
    logic [WIDTH-1:0]   r_n;        // captured modulus
    logic [WIDTH:0]     r_rem;      // partial remainder, one guard bit for the shift
    logic [CNT_W-1:0]   r_cnt;      // iterations completed
    logic [WIDTH-1:0]   r_result;

    logic [WIDTH:0]     w_shifted;
    logic [WIDTH:0]     w_rem_next;
    logic               w_last;

    // One restoring step: bring in the next dividend bit, then subtract the
    // modulus if it fits. With in_n = 0 the subtraction is a no-op, so the
    // remainder ends up equal to the dividend.
    always_comb begin
        w_shifted  = (r_rem << 1) | {{WIDTH{1'b0}}, r_a[WIDTH-1]};
        w_rem_next = (w_shifted >= {1'b0, r_n}) ? (w_shifted - {1'b0, r_n}) : w_shifted;
        w_last     = (r_cnt == CNT_W'(WIDTH - 1));
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses non-blocking assignments, so every
        // register samples the values from before the edge, whatever the order.
        if (resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and output decode.
    always_comb begin
        // NOTE: defaults come first so every path assigns every output. Leaving
        // one unassigned on some branch would infer a latch.
        w_state_next = r_state;
        w_done       = 1'b0;
        case (r_state)
            IDLE: if (start) w_state_next = RUN;
            RUN:  if (w_last) w_state_next = DONE;
            DONE: begin
                w_done       = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath. Operands are copied on the accepting edge, so later changes
    // on in_a/in_n cannot disturb an operation in flight.
    always_ff @(posedge clk) begin
        if (resetn) begin
            r_a      <= '0;
            r_n      <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a   <= in_a;
                        r_n   <= in_n;
                        r_rem <= '0;
                        r_cnt <= '0;
                    end
                end
                RUN: begin
                    r_rem <= w_rem_next;
                    r_a   <= r_a << 1;
                    r_cnt <= r_cnt + CNT_W'(1);
                    // The final step writes result on the same edge that enters DONE.
                    if (w_last) begin
                        r_result <= w_rem_next[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;
    assign done   = w_done;

endmodule

// File: tb/tb_mod_reduce.sv
// -----------------------------------------------------------------------------
// tb_mod_reduce
//   Self-checking bench for mod_reduce (WIDTH = 512). The reference model
//   computes the remainder directly with the '%' operator. Known vectors,
//   randomized operands, mid-run reset, ignored restarts and back-to-back
//   operations from a held start are all checked.
// -----------------------------------------------------------------------------
module tb_mod_reduce;

    localparam int W = 512;

    logic         clk = 1'b0;
    logic         resetn;
    logic         start;
    logic [W-1:0] in_a;
    logic [W-1:0] in_n;
    logic [W-1:0] result;
    logic         done;

    int n_checks = 0;
    int n_fail   = 0;

    mod_reduce #(.WIDTH(W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .in_a   (in_a),
        .in_n   (in_n),
        .result (result),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: mathematical remainder, with the defined n = 0 behaviour.
    function automatic logic [W-1:0] ref_mod(input logic [W-1:0] a, input logic [W-1:0] n);
        return (n == '0) ? a : (a % n);
    endfunction

    function automatic logic [W-1:0] rand_wide();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Wait up to budget rising edges for done. Samples 1 time unit after each
    // edge. lat = number of edges waited, or -1 if done never appeared.
    task automatic wait_done(input int budget, output int lat);
        lat = -1;
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    // One complete operation. The inputs are scrambled after the accepting
    // edge, so the result must come from the captured operands.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] n,
                          input logic [W-1:0] exp);
        int           lat;
        logic [W-1:0] held;
        @(negedge clk);
        in_a  = a;
        in_n  = n;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        in_a  = ~a;
        in_n  = n ^ rand_wide();
        wait_done(W + 20, lat);
        check({tag, " latency"}, W'(lat), W'(W));
        check({tag, " result"}, result, exp);
        held = result;
        @(posedge clk); #1;
        check({tag, " done width"}, W'(done), W'(0));
        repeat (3) @(posedge clk);
        #1;
        check({tag, " result hold"}, result, held);
    endtask

    initial begin
        logic [W-1:0] a, n, ones, half, exp1;
        int           lat, pulses, first_cyc, second_cyc;
        logic [W-1:0] r1, r2;

        resetn = 1'b1;
        start  = 1'b0;
        in_a   = '0;
        in_n   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset done", W'(done), W'(0));
        check("reset result", result, '0);
        // Start is high during the reset edge: reset must win.
        start = 1'b1;
        in_a  = W'(100);
        in_n  = W'(7);
        @(posedge clk); #1;
        resetn = 1'b0;
        start  = 1'b0;
        wait_done(W + 20, lat);
        check("reset beats start", W'(lat < 0), W'(1));

        // Spec vector and small known cases.
        run_op("vec512",
               512'hf59b616f4026145c9523c601567ab75c920002e59a5e3385d77c05dba137b0a3657a23da39ac57cc8884d23a01fb24c6f4d93bad497ce2247ee5ea907e3e0765,
               512'h9b524c36e3d2fd92b935c6082478574be7cc66dd17cbb37d4a4155a21613505cae6ace3bd697f929552b593a51f2ee77ae139a6ec6d61ca58cf7f64ff2e3c663,
               512'h5a4915385c5316c9dbedfff932026010aa339c08829280088d3ab0398b246046b70f559e63145ea3335978ffb008364f46c5a13e82a6c57ef1edf4408b5a4102);
        run_op("100mod7", W'(100), W'(7), W'(2));
        run_op("5mod7", W'(5), W'(7), W'(5));
        run_op("a_eq_n", W'(16'h1234), W'(16'h1234), W'(0));
        ones = '1;
        run_op("ones_mod3", ones, W'(3), W'(0));
        half = '0;
        half[W-1] = 1'b1;
        run_op("ones_mod_half", ones, half, half - W'(1));
        run_op("n_zero", W'(16'hABCD), W'(0), W'(16'hABCD));

        // Randomized operands: full width, small modulus, and a < n.
        for (int t = 0; t < 6; t++) begin
            a = rand_wide();
            case (t % 3)
                0:       n = rand_wide();
                1:       n = W'($urandom_range(1, 1000));
                default: n = a | (W'(1) << (W - 1));
            endcase
            if (t % 3 == 2) a = a >> 1;   // force a < n
            run_op($sformatf("rand%0d", t), a, n, ref_mod(a, n));
        end

        // Reset during iteration 200: no done, result cleared, then a clean restart.
        @(negedge clk);
        in_a  = rand_wide();
        in_n  = W'(12345);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        resetn = 1'b0;
        check("midrun reset result", result, '0);
        wait_done(W + 100, lat);
        check("midrun reset no done", W'(lat < 0), W'(1));
        run_op("after reset", W'(100), W'(7), W'(2));

        // Restart pulse and operand changes during RUN must be ignored.
        a    = rand_wide();
        n    = rand_wide() >> 7;
        exp1 = ref_mod(a, n);
        @(negedge clk);
        in_a  = a;
        in_n  = n;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        start = 1'b1;
        in_a  = W'(100);
        in_n  = W'(7);
        @(posedge clk); #1;
        start  = 1'b0;
        pulses = 0;
        r1     = '0;
        for (int k = 0; k < 1100; k++) begin
            @(posedge clk); #1;
            if (done) begin
                if (pulses == 0) r1 = result;
                pulses++;
            end
        end
        check("ignored restart pulses", W'(pulses), W'(1));
        check("ignored restart result", r1, exp1);

        // Start held high: two operations, done pulses 514 edges apart.
        a    = rand_wide();
        n    = W'($urandom_range(3, 99999));
        exp1 = ref_mod(a, n);
        @(negedge clk);
        in_a  = a;
        in_n  = n;
        start = 1'b1;
        pulses     = 0;
        first_cyc  = -1;
        second_cyc = -1;
        r2         = '0;
        for (int cyc = 0; cyc < 1200; cyc++) begin
            @(posedge clk); #1;
            if (done) begin
                pulses++;
                if (pulses == 1) begin
                    first_cyc = cyc;
                    r1 = result;
                end else if (pulses == 2) begin
                    second_cyc = cyc;
                    r2 = result;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check("held start pulses", W'(pulses), W'(2));
        check("held start first latency", W'(first_cyc), W'(W));
        check("held start spacing", W'(second_cyc - first_cyc), W'(W + 2));
        check("held start result1", r1, exp1);
        check("held start result2", r2, exp1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mod_reduce.md
MOD_REDUCE -- requirements
Module: mod_reduce

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter WIDTH, default 512: operand and result width in bits.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 resetn  input  1  synchronous active-high reset; the port keeps the codebase name but is asserted high.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 in_a  input  WIDTH  dividend, unsigned.
REQ-007 in_n  input  WIDTH  modulus, unsigned.
REQ-008 result  output  WIDTH  registered remainder in_a mod in_n.
REQ-009 done  output  1  one-cycle completion pulse.

Function
REQ-010 The block SHALL compute result = in_a mod in_n for any unsigned in_a and nonzero in_n, including in_a < in_n, in_a = in_n and in_a ≥ 2·in_n.
REQ-011 Algorithm: restoring shift-subtract, one dividend bit per cycle, MSB first.
- r ← (r<<1) | a[i].
- If r ≥ n then r ← r − n.
- r is held on WIDTH+1 bits so the shift never overflows.
REQ-012 States SHALL be IDLE, RUN and DONE.
- IDLE → RUN on the edge that samples start=1.
- RUN → DONE after the WIDTH-th iteration.
- DONE → IDLE unconditionally on the next edge.
REQ-013 On the start-sampling edge the block SHALL capture in_a and in_n into internal registers, clear r and clear the bit counter; later input changes SHALL NOT affect the operation.
REQ-014 RUN SHALL perform exactly WIDTH iterations, one per edge.
REQ-015 Timing relative to the start-sampling edge E0:
- done=1 during exactly the cycle following edge E0+WIDTH (edge 512 for default WIDTH).
- result is valid in that same cycle.
REQ-016 done SHALL be high only in DONE, for exactly one cycle per accepted start.
REQ-017 result SHALL be updated only on entry to DONE and SHALL hold its value until the next completion or reset.
REQ-018 start asserted in RUN or DONE SHALL be ignored, with no queuing.
REQ-019 start held high continuously SHALL start a new operation on each return to IDLE.
REQ-020 in_n = 0: the block SHALL return result = in_a after the normal latency, with done pulsed as usual.
REQ-021 Comparison and subtraction SHALL be unsigned, full width, with no truncation of the final remainder; result < in_n always when in_n ≠ 0.

Reset
REQ-022 While resetn=1 at a rising edge, the block SHALL:
- enter IDLE;
- set done=0 and result=0;
- clear the counter, r and the operand registers.
REQ-023 Reset asserted mid-RUN SHALL abort the operation with no done pulse; the first start after reset release SHALL be accepted normally.
REQ-024 Reset has priority over start on the same edge.

Verification
REQ-025 WIDTH=512 vector:
- in_a=0xf59b616f4026145c9523c601567ab75c920002e59a5e3385d77c05dba137b0a3657a23da39ac57cc8884d23a01fb24c6f4d93bad497ce2247ee5ea907e3e0765
- in_n=0x9b524c36e3d2fd92b935c6082478574be7cc66dd17cbb37d4a4155a21613505cae6ace3bd697f929552b593a51f2ee77ae139a6ec6d61ca58cf7f64ff2e3c663
- start pulsed for 1 cycle → result=0x5a4915385c5316c9dbedfff932026010aa339c08829280088d3ab0398b246046b70f559e63145ea3335978ffb008364f46c5a13e82a6c57ef1edf4408b5a4102, done high exactly 512 cycles after the start edge, for 1 cycle.
REQ-026 in_a=100, in_n=7 → result=2; in_a=5, in_n=7 → 5; in_a=in_n=0x1234 → 0.
REQ-027 in_a=2^512−1, in_n=3 → result=0; in_a=2^512−1, in_n=2^511 → 2^511−1.
REQ-028 in_n=0, in_a=0xABCD → result=0xABCD after normal latency.
REQ-029 Reset for 1 cycle at iteration 200 → no done pulse, result=0; restart with 100 mod 7 → 2.
REQ-030 Operand and start disturbances:
- start re-pulsed and in_a/in_n changed during RUN → ignored; first result unaffected; exactly one done pulse.
- start held high for two operations → two done pulses, 514 edges apart (512-edge RUN + DONE + IDLE re-accept).
